// File: rtl/cpu16_execute.sv
// -----------------------------------------------------------------------------
// cpu16_execute
//   Operand-fetch / execute / writeback pipeline wrapped around an external
//   combinational cpu16 ALU. Decoded instructions are accepted over a
//   valid/ready port, operands are read from the register file (with full
//   forwarding from the in-flight E and W stages), the ALU operands are
//   registered in stage E, the ALU result is captured in stage W, and the
//   W entry retires downstream while writing back into the register file.
//   Because every hazard is forwarded, downstream backpressure is the only
//   source of stalls.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   instruction handshake (accepted when both high)
//   in_op                 ALU opcode, carried unchanged to alu_op
//   in_srca / in_srcb     source register indices for x / y
//   in_imm / in_use_imm   immediate y operand and its select
//   in_dst / in_wb        destination index and writeback enable
//   alu_op/alu_x/alu_y    stage-E contents presented to the ALU
//   alu_r                 combinational ALU result for stage-E contents
//   out_valid / out_ready retire handshake (retire when both high)
//   out_data/out_dst/out_wb  stage-W result, destination, writeback flag
// -----------------------------------------------------------------------------
module cpu16_execute #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [AW-1:0] in_srca,
    input  logic [AW-1:0] in_srcb,
    input  logic [15:0]   in_imm,
    input  logic          in_use_imm,
    input  logic [AW-1:0] in_dst,
    input  logic          in_wb,

    output logic [3:0]    alu_op,
    output logic [15:0]   alu_x,
    output logic [15:0]   alu_y,
    input  logic [15:0]   alu_r,

    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_data,
    output logic [AW-1:0] out_dst,
    output logic          out_wb
);

    localparam int NREG = 2 ** AW;

    // Register file; entry 0 is never written and never read.
    logic [15:0]   rf_q [NREG];

    // Stage E (operands presented to the ALU)
    logic          e_valid_q,  e_valid_d;
    logic [3:0]    alu_op_q,   alu_op_d;
    logic [15:0]   alu_x_q,    alu_x_d;
    logic [15:0]   alu_y_q,    alu_y_d;
    logic [AW-1:0] e_dst_q,    e_dst_d;
    logic          e_wb_q,     e_wb_d;

    // Stage W (captured ALU result awaiting retire)
    logic          out_valid_q, out_valid_d;
    logic [15:0]   out_data_q,  out_data_d;
    logic [AW-1:0] out_dst_q,   out_dst_d;
    logic          out_wb_q,    out_wb_d;

    logic          w_free;
    logic          accept;
    logic          rf_we;
    logic [15:0]   opa;
    logic [15:0]   opb;

    // W can take new contents when it is empty or retiring this cycle.
    // in_ready is combinational on out_ready so a retiring W lets a full
    // pipe keep streaming at one instruction per cycle.
    assign w_free   = !out_valid_q || out_ready;
    assign in_ready = !e_valid_q || w_free;
    assign accept   = in_valid && in_ready;
    assign rf_we    = out_valid_q && out_ready && out_wb_q && (out_dst_q != '0);

    // Source operand lookup. E is younger than W, so it wins. The W path
    // also covers the case where W retires (and writes the register file)
    // on the same edge that this instruction is accepted. Neither path
    // depends on out_ready: a stalled W entry is still the newest value.
    function automatic logic [15:0] src_val(input logic [AW-1:0] src);
        if (src == '0)
            return 16'h0000;
        else if (e_valid_q && e_wb_q && (e_dst_q == src))
            return alu_r;
        else if (out_valid_q && out_wb_q && (out_dst_q == src))
            return out_data_q;
        else
            return rf_q[src];
    endfunction

    always_comb begin
        opa = src_val(in_srca);
        opb = in_use_imm ? in_imm : src_val(in_srcb);
    end

    // Next-state for E and W
    always_comb begin
        e_valid_d   = e_valid_q;
        alu_op_d    = alu_op_q;
        alu_x_d     = alu_x_q;
        alu_y_d     = alu_y_q;
        e_dst_d     = e_dst_q;
        e_wb_d      = e_wb_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_dst_d   = out_dst_q;
        out_wb_d    = out_wb_q;

        if (w_free) begin
            out_valid_d = e_valid_q;
            out_data_d  = alu_r;
            out_dst_d   = e_dst_q;
            out_wb_d    = e_wb_q;
        end

        if (accept) begin
            e_valid_d = 1'b1;
            alu_op_d  = in_op;
            alu_x_d   = opa;
            alu_y_d   = opb;
            e_dst_d   = in_dst;
            e_wb_d    = in_wb;
        end else if (w_free) begin
            // E moved into W with nothing behind it
            e_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid_q   <= 1'b0;
            alu_op_q    <= '0;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            e_dst_q     <= '0;
            e_wb_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_dst_q   <= '0;
            out_wb_q    <= 1'b0;
        end else begin
            e_valid_q   <= e_valid_d;
            alu_op_q    <= alu_op_d;
            alu_x_q     <= alu_x_d;
            alu_y_q     <= alu_y_d;
            e_dst_q     <= e_dst_d;
            e_wb_q      <= e_wb_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_dst_q   <= out_dst_d;
            out_wb_q    <= out_wb_d;
        end
    end

    // Writeback happens on the retire edge; r0 is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[out_dst_q] <= out_data_q;
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_dst   = out_dst_q;
    assign out_wb    = out_wb_q;

endmodule

// File: tb/tb_cpu16_execute.sv
module tb_cpu16_execute;

    localparam int AW = 3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [AW-1:0] in_srca;
    logic [AW-1:0] in_srcb;
    logic [15:0]   in_imm;
    logic          in_use_imm;
    logic [AW-1:0] in_dst;
    logic          in_wb;
    logic [3:0]    alu_op;
    logic [15:0]   alu_x;
    logic [15:0]   alu_y;
    logic [15:0]   alu_r;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic [AW-1:0] out_dst;
    logic          out_wb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0]   data;
        logic [AW-1:0] dst;
        logic          wb;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mreg [8];

    always #5 clk = ~clk;

    cpu16_execute #(.AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_srca    (in_srca),
        .in_srcb    (in_srcb),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .in_dst     (in_dst),
        .in_wb      (in_wb),
        .alu_op     (alu_op),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_r      (alu_r),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_dst    (out_dst),
        .out_wb     (out_wb)
    );

    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            default: return x ^ y;
        endcase
    endfunction

    // Stand-in for the cpu16 ALU
    always_comb alu_r = alu_f(alu_op, alu_x, alu_y);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    // The sequential-semantics model computes the expected result at acceptance.
    task automatic send(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [15:0] imm, input logic ui, input logic [2:0] d, input logic wb);
        logic        acc;
        logic [15:0] ax, by;
        exp_t        e;
        in_valid = 1'b1; in_op = op; in_srca = a; in_srcb = b;
        in_imm = imm; in_use_imm = ui; in_dst = d; in_wb = wb;
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            #1 acc = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) begin
            chk("send_timeout", 32'd0, 32'd1);
        end else begin
            ax = (a == 0) ? 16'h0 : mreg[a];
            by = ui ? imm : ((b == 0) ? 16'h0 : mreg[b]);
            e.data = alu_f(op, ax, by); e.dst = d; e.wb = wb;
            sb.push_back(e);
            if (wb && d != 0) mreg[d] = e.data;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
    endtask

    // Retire monitor: out_ready/out_valid are stable from just after the falling edge
    always begin
        @(negedge clk);
        #2;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("extra_retire", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("retire", {11'd0, out_wb, out_dst, out_data}, {11'd0, e.wb, e.dst, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
        reset = 1'b1; in_valid = 1'b0; in_op = 4'h0; in_srca = '0; in_srcb = '0;
        in_imm = 16'h0; in_use_imm = 1'b0; in_dst = '0; in_wb = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu", {alu_op, alu_x, alu_y}, 0);
        chk("rst_out", {out_wb, out_dst, out_data}, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: back-to-back with E forwarding, no bubble
        send(OP_ADD, 3'd0, 3'd0, 16'd5, 1'b1, 3'd1, 1'b1);
        chk("t1_alu_e", {alu_op, alu_x, alu_y}, {OP_ADD, 16'd0, 16'd5});
        chk("t1_lat_w_empty", out_valid, 0);
        send(OP_ADD, 3'd1, 3'd0, 16'd3, 1'b1, 3'd2, 1'b1);
        chk("t1_fwd_x", alu_x, 16'd5);
        chk("t1_w0", {out_valid, out_data}, {1'b1, 16'd5});
        @(negedge clk);
        chk("t1_w1", {out_valid, out_data}, {1'b1, 16'd8});
        drain();
        send(OP_ADD, 3'd2, 3'd0, 16'd0, 1'b1, 3'd0, 1'b0);
        chk("t1_r2_read", alu_x, 16'd8);
        drain();

        // 2: dependency chain on r1
        send(OP_ADD, 3'd0, 3'd0, 16'd0, 1'b1, 3'd1, 1'b1);
        for (int i = 0; i < 4; i++) send(OP_ADD, 3'd1, 3'd0, 16'd1, 1'b1, 3'd1, 1'b1);
        drain();

        // 4: r0 write ignored, r0 reads as zero
        send(OP_ADD, 3'd0, 3'd0, 16'hFFFF, 1'b1, 3'd0, 1'b1);
        send(OP_SUB, 3'd0, 3'd0, 16'd3, 1'b1, 3'd4, 1'b1);
        chk("t4_r0_x", {alu_op, alu_x}, {OP_SUB, 16'd0});
        drain();

        // 6: wb=0 does not write or forward; x and y on the same register
        send(OP_ADD, 3'd0, 3'd0, 16'd7, 1'b1, 3'd3, 1'b1);
        drain();
        send(OP_ADD, 3'd0, 3'd0, 16'd9, 1'b1, 3'd3, 1'b0);
        send(OP_ADD, 3'd3, 3'd0, 16'd0, 1'b1, 3'd5, 1'b1);
        chk("t6_nofwd_x", alu_x, 16'd7);
        send(OP_ADD, 3'd5, 3'd5, 16'd0, 1'b0, 3'd6, 1'b1);
        chk("t6_same_xy", {alu_x, alu_y}, {16'd7, 16'd7});
        drain();

        // 3: backpressure with three queued instructions
        out_ready = 1'b0;
        send(OP_ADD, 3'd0, 3'd0, 16'h11, 1'b1, 3'd6, 1'b1);
        send(OP_ADD, 3'd6, 3'd0, 16'h1, 1'b1, 3'd7, 1'b1);
        fork
            send(OP_ADD, 3'd7, 3'd0, 16'h1, 1'b1, 3'd1, 1'b1);
            begin
                for (int i = 0; i < 4; i++) begin
                    chk("t3_in_ready", in_ready, 0);
                    chk("t3_w_hold", {out_valid, out_dst, out_data}, {1'b1, 3'd6, 16'h11});
                    chk("t3_e_hold", {alu_x, alu_y}, {16'h11, 16'h1});
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // 5: reset with E and W both occupied
        out_ready = 1'b0;
        send(OP_ADD, 3'd0, 3'd0, 16'h55, 1'b1, 3'd2, 1'b1);
        send(OP_ADD, 3'd2, 3'd0, 16'h1, 1'b1, 3'd1, 1'b1);
        chk("t5_pre_full", {out_valid, in_ready}, 2'b10);
        reset = 1'b1;
        #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_alu", {alu_op, alu_x, alu_y}, 0);
        sb.delete();
        for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        send(OP_ADD, 3'd2, 3'd0, 16'd0, 1'b1, 3'd0, 1'b0);
        chk("t5_r2_zero", alu_x, 16'd0);
        send(OP_ADD, 3'd1, 3'd0, 16'd0, 1'b1, 3'd0, 1'b0);
        chk("t5_r1_zero", alu_x, 16'd0);
        send(OP_ADD, 3'd3, 3'd0, 16'd0, 1'b1, 3'd0, 1'b0);
        chk("t5_r3_zero", alu_x, 16'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
